// File: rtl/inst_fetch_unit.sv
// Instruction-fetch unit: owns the PC, drives a zero-latency ROM, buffers {pc,inst} in a small FIFO
// and hands them to IF/ID over valid/ready. Optional range check enabled by FETCH_BOUND_CHECK_EN.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          FB_DEPTH  = 2,
  parameter int          ROM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  input  logic        id_ready_i,
  input  logic [31:0] rom_inst_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        fetch_err_o
);

  localparam int PTR_W = $clog2(FB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if ((RESET_PC[1:0] != 2'b00) || (FB_DEPTH < 2) ||
      ((FB_DEPTH & (FB_DEPTH - 1)) != 0) || (ROM_WORDS < 1)) begin : g_bad_param
    $error("inst_fetch_unit: illegal parameter value");
  end

  logic [31:0]      pc;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      fb_pc   [FB_DEPTH];
  logic [31:0]      fb_inst [FB_DEPTH];
  logic [31:0]      hold_pc, hold_inst;
  logic             redirect, has_space, in_range, push, pop;

  assign rom_addr_o = pc;
  assign if_valid_o = (count != '0);

  // A redirect discards the buffer, so a simultaneous handshake is not a real pop.
  assign redirect  = rom_ce_o & branch_flag_i;
  assign pop       = if_valid_o & id_ready_i & ~redirect;
  assign has_space = (count < CNT_W'(FB_DEPTH)) | (if_valid_o & id_ready_i);
  assign push      = rom_ce_o & ~branch_flag_i & has_space & in_range;

`ifdef FETCH_BOUND_CHECK_EN
  localparam logic [29:0] ROM_LIMIT = 30'(ROM_WORDS);
  logic fetch_err;

  assign in_range    = (pc[31:2] < ROM_LIMIT);
  assign fetch_err_o = fetch_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_err <= 1'b0;
    end else if (rom_ce_o && !branch_flag_i && has_space && !in_range) begin
      fetch_err <= 1'b1;
    end
  end
`else
  assign in_range    = 1'b1;
  assign fetch_err_o = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_ce_o <= 1'b0;
      pc       <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      rom_ce_o <= 1'b1;
      if (redirect) begin
        pc     <= branch_target_address_i & ~32'h3;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc     <= pc + 32'd4;
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: buffer storage has no reset; entries are only observed once count marks them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fb_pc[wr_ptr]   <= pc;
      fb_inst[wr_ptr] <= rom_inst_i;
    end
  end

  // Remember the last presented head so the outputs hold steady while the buffer is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_pc   <= '0;
      hold_inst <= '0;
    end else if (if_valid_o) begin
      hold_pc   <= fb_pc[rd_ptr];
      hold_inst <= fb_inst[rd_ptr];
    end
  end

  assign if_pc_o   = if_valid_o ? fb_pc[rd_ptr]   : hold_pc;
  assign if_inst_o = if_valid_o ? fb_inst[rd_ptr] : hold_inst;

endmodule
